// File: rtl/alu_acc_sequencer.sv
// Command sequencer for the 16-bit ALU/accumulator: accepts one opcode+operand,
// drives BR and one-cycle ALU strobes, then holds the captured ACC/flags response.
module alu_acc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic [15:0] br_out,
    output logic        c8,
    output logic        c9,
    output logic        c13,
    output logic        c15,
    output logic        c16,
    output logic        c17,
    output logic        c18,
    output logic        c19,
    output logic        c20,
    output logic        c21
);

    localparam logic [3:0] OP_CLR = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_LDA = 4'hA;
    localparam logic [3:0] OP_ILL = 4'hC;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC1 = 3'd1,
        EXEC2 = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] br_q, br_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_err_q, rsp_err_d;
    logic [9:0]  strobe;
    logic        accept;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid must not depend on ready, and ready here is a registered output.
    assign accept = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        br_d         = br_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        strobe       = 10'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC1;
                    op_d    = cmd_op;
                    if (cmd_op <= OP_LDA) br_d = cmd_data;
                end
            end
            EXEC1: begin
                // strobe bit index follows the c8,c9,c13..c21 output order
                case (op_q)
                    OP_CLR:  strobe[0] = 1'b1;
                    OP_ADD:  strobe[1] = 1'b1;
                    OP_SUB:  strobe[2] = 1'b1;
                    OP_MUL:  strobe[3] = 1'b1;
                    OP_DIV:  strobe[4] = 1'b1;
                    OP_SHL:  strobe[5] = 1'b1;
                    OP_SHR:  strobe[6] = 1'b1;
                    OP_AND:  strobe[7] = 1'b1;
                    OP_OR:   strobe[8] = 1'b1;
                    OP_NOT:  strobe[9] = 1'b1;
                    OP_LDA:  strobe[0] = 1'b1;
                    default: strobe    = 10'd0;
                endcase
                state_d = (op_q == OP_LDA) ? EXEC2 : CAPT;
            end
            EXEC2: begin
                strobe[1] = 1'b1;
                state_d   = CAPT;
            end
            CAPT: begin
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_out;
                rsp_flags_d  = alu_flags;
                rsp_err_d    = (op_q >= OP_ILL) || ((op_q == OP_DIV) && (br_q == 16'd0));
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is a flop that anticipates the next state, so it rises on the
    // same edge that retires the response.
    assign cmd_ready_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= 4'd0;
            br_q         <= 16'd0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'd0;
            rsp_flags_q  <= 4'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            br_q         <= br_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign br_out     = br_q;

    assign c8  = strobe[0];
    assign c9  = strobe[1];
    assign c13 = strobe[2];
    assign c15 = strobe[3];
    assign c16 = strobe[4];
    assign c17 = strobe[5];
    assign c18 = strobe[6];
    assign c19 = strobe[7];
    assign c20 = strobe[8];
    assign c21 = strobe[9];

endmodule

// File: doc/alu_acc_sequencer.md
# alu_acc_sequencer

Command sequencer for the 16-bit ALU/accumulator datapath. It accepts one opcode+operand command at a time over a valid/ready handshake and loads the operand into the B register it drives onto `br_out`. It pulses exactly one ALU control strobe per execute cycle (two for the load-accumulator macro-op), then captures the accumulator and flags into a held response. It sits between the instruction-decode stage and the ALU, and it is the only block that drives the ALU's C-strobes and BR input.

## Interface
- No parameters; widths fixed (16-bit data, 4-bit opcode, 4-bit flags).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 4: opcode.
- `cmd_data` in 16: operand.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response consumed.
- `rsp_result` out 16: captured accumulator.
- `rsp_flags` out 4: captured ALU flags {ZF,CF,OF,SF}.
- `rsp_err` out 1: illegal opcode, or DIV with operand 0.
- `alu_out` in 16: ALU accumulator value.
- `alu_flags` in 4: ALU flag register.
- `br_out` out 16: B-register value driven to the ALU.
- `c8` out 1: clear strobe. `c9` out 1: add strobe. `c13` out 1: sub strobe. `c15` out 1: mul strobe. `c16` out 1: div strobe.
- `c17` out 1: shl strobe. `c18` out 1: shr strobe. `c19` out 1: and strobe. `c20` out 1: or strobe. `c21` out 1: not strobe.

## Operation
- Opcodes: 0 CLR→c8, 1 ADD→c9, 2 SUB→c13, 3 MUL→c15, 4 DIV→c16, 5 SHL→c17, 6 SHR→c18, 7 AND→c19, 8 OR→c20, 9 NOT→c21, A LDA→c8 then c9, B NOP (no strobe, reads ACC), C–F illegal.
- FSM states: IDLE, EXEC1, EXEC2, CAPT, RESP.
  - IDLE→EXEC1 on accept (`cmd_valid && cmd_ready`).
  - EXEC1→EXEC2 if LDA, otherwise EXEC1→CAPT.
  - EXEC2→CAPT.
  - CAPT→RESP.
  - RESP→IDLE when `rsp_ready`.
- On accept, latch the opcode. `br_out <= cmd_data` for opcodes 0–A. For B and C–F, `br_out` is unchanged.
- Strobe invariant: at most one of c8…c21 is high in any cycle. Strobes are high only in EXEC1/EXEC2, are combinational from state+latched opcode, and last exactly one cycle each.
- NOP and illegal opcodes pass through EXEC1 with no strobe.
- CAPT: at the edge leaving CAPT, `rsp_result <= alu_out` and `rsp_flags <= alu_flags`.
- `rsp_err` is set for opcodes C–F, or for DIV when `br_out == 0`. For DIV-by-zero, c16 is still pulsed; the ALU leaves ACC unchanged.
- Flags are passed through unmodified; the sequencer does no arithmetic.
- `cmd_ready` is registered. It is 1 only in IDLE and drops at the accept edge.
- RESP: `rsp_valid`, `rsp_result`, `rsp_flags` and `rsp_err` are held stable until `rsp_ready`. The handshake edge returns the FSM to IDLE and clears `rsp_valid`.

## Timing
- Reset (async, immediate):
  - FSM = IDLE.
  - `cmd_ready = 0`; it rises at the first rising edge after `rst_n` deasserts.
  - `rsp_valid = 0`, `rsp_result = 0`, `rsp_flags = 0`, `rsp_err = 0`, `br_out = 0`.
  - All strobes 0.
- Accept at edge T:
  - EXEC1 strobe is high during cycle T→T+1; the ALU updates ACC/flags at edge T+1.
  - Single-step ops: capture at edge T+2; `rsp_valid` high from T+2.
  - LDA: c8 high T→T+1, c9 high T+1→T+2; `rsp_valid` high from T+3.
- RESP→IDLE at the edge with `rsp_ready = 1`. `cmd_ready` is high from that same edge, so there is no same-cycle response→command overlap. Minimum command period is 4 cycles (5 for LDA).
- `cmd_*` inputs are ignored when `cmd_ready = 0`.
- Reset mid-operation (any state): strobes drop combinationally and the response is discarded. The ALU shares `rst_n`, so ACC also resets.

## Test plan
- Reset release, then LDA 0x1234 → c8 high one cycle then c9 high one cycle; `rsp_valid` 3 cycles after accept; `rsp_result = 0x1234`, `rsp_err = 0`.
- LDA 0xFFFF, then ADD 0x0001 → `rsp_result = 0x0000`, `rsp_flags = 4'b1100`; only c9 pulsed for the ADD.
- LDA 0x0010, then DIV 0x0000 → c16 pulsed once; `rsp_result = 0x0010`, `rsp_err = 1`.
- ACC = 0x00AB, `br_out` = 0x00AB, then opcode 0xD with data 0x5555 → no strobe in any cycle; `br_out` stays 0x00AB; `rsp_result = 0x00AB`, `rsp_err = 1`.
- Hold `rsp_ready = 0` for 5 cycles after `rsp_valid` → response fields stable, `cmd_ready = 0`, `cmd_valid` pulses ignored. Then `rsp_ready = 1` → `rsp_valid` falls and `cmd_ready` rises at the same edge.
- Assert `rst_n = 0` during EXEC2 of an LDA → c9 drops immediately; `rsp_valid = 0`, `cmd_ready = 0` until the first edge after release; no response is ever produced for that command.
